rotor_stepper: RTL and testbench
================================

Name: rotor_stepper

Overview:
- Holds the live positions of the three rotors of the Enigma datapath. Advances them on every keypress using notch-driven stepping.
- Loaded from the three per-rotor initial-position latches (ROTOR_POS 0/1/2) during configuration.
- Feeds the substitution path, which reads pos_0..pos_2 to offset each rotor wiring lookup.
- Rotor 0 is the rightmost, fastest rotor. Rotor 2 is the leftmost.

Parameters:
- NOTCH_0, 16, turnover position of rotor 0 (0..25).
- NOTCH_1, 4, turnover position of rotor 1 (0..25).
- NOTCH_2, 21, turnover position of rotor 2 (0..25). Reserved for a fourth stage; it does not affect stepping.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  latch init_0..init_2 into the rotor positions.
- init_0  in  5  initial position, rotor 0.
- init_1  in  5  initial position, rotor 1.
- init_2  in  5  initial position, rotor 2.
- step_valid  in  1  keypress request.
- step_ready  out  1  block can accept a step.
- pos_0  out  5  current position, rotor 0.
- pos_1  out  5  current position, rotor 1.
- pos_2  out  5  current position, rotor 2.
- pos_valid  out  1  one-cycle pulse: positions were just stepped.
- cfg_err  out  1  sticky flag: an init value was 26 or greater.

Behaviour:
- Reset (async, rst_n=0):
  - pos_0..pos_2 = 0; pos_valid = 0; cfg_err = 0; step_ready = 0; FSM = UNCFG.
  - Reset deasserted mid-step: the step is lost; the block stays in UNCFG.
- FSM states: UNCFG, IDLE, BUSY.
  - UNCFG: step_ready = 0; step_valid is ignored; load_en moves the FSM to IDLE.
  - IDLE: step_ready = 1. A step is accepted on a clock edge where step_valid = 1, step_ready = 1 and load_en = 0. On that edge the positions update and the FSM moves to BUSY.
  - BUSY: lasts exactly one cycle; step_ready = 0; pos_valid = 1; then returns to IDLE.
- Throughput and latency:
  - At most one step every 2 cycles.
  - New positions are visible in the cycle after the accepting edge, and that is the same cycle pos_valid is high.
  - step_valid held high produces one step per 2 cycles.
- Load:
  - load_en = 1 in any state takes priority: positions are latched at the edge and the FSM goes to IDLE.
  - pos_valid is not asserted for a load.
  - A step_valid in the same cycle is dropped, not queued.
  - An init value of 26 or greater loads 0 for that rotor and sets cfg_err.
  - cfg_err clears only on reset.
- Stepping rules. All decisions use the positions before the step.
  - r_at = (pos_0 == NOTCH_0); m_at = (pos_1 == NOTCH_1).
  - Rotor 0 always advances.
  - Rotor 1 advances if r_at, or (with the optional feature) if m_at.
  - Rotor 2 advances per the optional feature rules.
- Arithmetic:
  - Each advance is +1 modulo 26: 25 wraps to 0.
  - Positions never leave the range 0..25.

Optional Feature:
- Macro: DOUBLE_STEP_EN.
- Defined (historical Enigma double-step):
  - Rotor 1 advances if r_at or m_at.
  - Rotor 2 advances if m_at.
  - Example: the middle rotor steps on two consecutive keypresses.
- Undefined (pure odometer):
  - Rotor 1 advances only if r_at.
  - Rotor 2 advances only if r_at and m_at.

Decomposition:
- Shared package enigma_pkg:
  - ALPHABET_LEN = 26; NUM_ROTORS = 3.
  - typedef logic [4:0] pos_t.
  - enum stepper_state_t {UNCFG, IDLE, BUSY}.
  - function inc_mod26(pos_t).
- Sub-module rotor_counter, instantiated 3 times:
  - Mod-26 register with async active-low reset.
  - Priority load over increment.
  - Range check that drives a per-rotor err bit; cfg_err is the OR of the three bits.
- Notch compare and FSM live in rotor_stepper.

Test Plan:
1. Reset, then step_valid = 1 without load -> step_ready = 0, positions stay 0, no pos_valid.
2. Load (25, 25, 25) with default notches, then one step -> pos = (0, 25, 25); pos_valid pulses exactly one cycle after acceptance; step_ready is low in that cycle.
3. DOUBLE_STEP_EN defined: load (16, 3, 0), then two steps -> (17, 4, 0), then (18, 5, 1).
4. DOUBLE_STEP_EN undefined: same stimulus -> (17, 4, 0), then (18, 4, 0).
5. step_valid held high for 10 cycles from (0, 0, 0) -> exactly 5 steps, ending at (5, 0, 0). load_en with step_valid in the same cycle -> positions equal the init values and no pos_valid.
6. Load init_1 = 30 -> pos_1 = 0 and cfg_err = 1. A later valid load leaves cfg_err at 1. rst_n pulsed low while in BUSY -> all outputs 0 immediately (async) and FSM = UNCFG.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma datapath: rotor position type,
// stepper FSM states and modulo-26 increment.
package enigma_pkg;

    localparam int unsigned ALPHABET_LEN = 26;
    localparam int unsigned NUM_ROTORS   = 3;
    localparam int unsigned POS_W        = 5;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } stepper_state_t;

    // Advance one letter; 25 wraps to 0 and anything out of range collapses to 0.
    function automatic pos_t inc_mod26(input pos_t p);
        if (p >= pos_t'(ALPHABET_LEN - 1)) begin
            return '0;
        end
        return p + pos_t'(1);
    endfunction

endpackage

// File: rtl/rotor_counter.sv
// Single rotor position register: mod-26 counter with priority load and a
// sticky out-of-range flag for the loaded init value.
module rotor_counter
    import enigma_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [4:0] init_val,
    input  logic       inc_en,
    output logic [4:0] pos,
    output logic       err
);

    pos_t pos_d, pos_q;
    logic err_d, err_q;
    logic init_bad;

    always_comb begin
        init_bad = (init_val >= 5'(ALPHABET_LEN));
        pos_d    = pos_q;
        err_d    = err_q;
        if (load_en) begin
            pos_d = init_bad ? '0 : init_val;
            err_d = err_q | init_bad;
        end else if (inc_en) begin
            pos_d = inc_mod26(pos_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            err_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            err_q <= err_d;
        end
    end

    assign pos = pos_q;
    assign err = err_q;

endmodule

// File: rtl/rotor_stepper.sv
// Three-rotor position keeper with notch-driven stepping and a load/step FSM.
// Build option: define DOUBLE_STEP_EN for historical double-stepping; default is a pure odometer.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter int unsigned NOTCH_0 = 16,
    parameter int unsigned NOTCH_1 = 4,
    parameter int unsigned NOTCH_2 = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [4:0] init_0,
    input  logic [4:0] init_1,
    input  logic [4:0] init_2,
    input  logic       step_valid,
    output logic       step_ready,
    output logic [4:0] pos_0,
    output logic [4:0] pos_1,
    output logic [4:0] pos_2,
    output logic       pos_valid,
    output logic       cfg_err
);

    // NOTCH_2 is kept for a future fourth stage; only its range is enforced here.
    if (NOTCH_0 >= ALPHABET_LEN || NOTCH_1 >= ALPHABET_LEN || NOTCH_2 >= ALPHABET_LEN) begin : g_notch_range
        $error("rotor_stepper: notch parameters must be in 0..25");
    end

    stepper_state_t state_d, state_q;
    logic step_ready_d, step_ready_q;
    logic pos_valid_d, pos_valid_q;
    logic step_acc;
    logic r_at, m_at;

    pos_t                  init_val [NUM_ROTORS];
    pos_t                  pos_cur  [NUM_ROTORS];
    logic [NUM_ROTORS-1:0] adv;
    logic [NUM_ROTORS-1:0] err;

    assign init_val[0] = init_0;
    assign init_val[1] = init_1;
    assign init_val[2] = init_2;

    // Load wins over everything; a step only lands from IDLE.
    always_comb begin
        state_d  = state_q;
        step_acc = 1'b0;
        case (state_q)
            UNCFG: state_d = UNCFG;
            IDLE: begin
                if (step_valid) begin
                    state_d  = BUSY;
                    step_acc = 1'b1;
                end
            end
            BUSY:    state_d = IDLE;
            default: state_d = UNCFG;
        endcase
        if (load_en) begin
            state_d  = IDLE;
            step_acc = 1'b0;
        end
        step_ready_d = (state_d == IDLE);
        pos_valid_d  = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNCFG;
            step_ready_q <= 1'b0;
            pos_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_ready_q <= step_ready_d;
            pos_valid_q  <= pos_valid_d;
        end
    end

    // Notch decisions use the pre-step positions.
    always_comb begin
        r_at   = (pos_cur[0] == pos_t'(NOTCH_0));
        m_at   = (pos_cur[1] == pos_t'(NOTCH_1));
        adv[0] = step_acc;
`ifdef DOUBLE_STEP_EN
        adv[1] = step_acc & (r_at | m_at);
        adv[2] = step_acc & m_at;
`else
        adv[1] = step_acc & r_at;
        adv[2] = step_acc & r_at & m_at;
`endif
    end

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        rotor_counter u_rotor (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en),
            .init_val (init_val[i]),
            .inc_en   (adv[i]),
            .pos      (pos_cur[i]),
            .err      (err[i])
        );
    end

    assign pos_0      = pos_cur[0];
    assign pos_1      = pos_cur[1];
    assign pos_2      = pos_cur[2];
    assign step_ready = step_ready_q;
    assign pos_valid  = pos_valid_q;
    assign cfg_err    = |err;

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed scenarios plus randomized
// load/step traffic against a behavioural Enigma stepping model.
module tb_rotor_stepper;

    localparam int N0 = 16;
    localparam int N1 = 4;

    logic       clk;
    logic       rst_n;
    logic       load_en;
    logic [4:0] init_0, init_1, init_2;
    logic       step_valid;
    logic       step_ready;
    logic [4:0] pos_0, pos_1, pos_2;
    logic       pos_valid;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pos [3];
    bit m_err, m_cfgd, m_busy, m_valid;

    rotor_stepper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .init_0     (init_0),
        .init_1     (init_1),
        .init_2     (init_2),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .pos_0      (pos_0),
        .pos_1      (pos_1),
        .pos_2      (pos_2),
        .pos_valid  (pos_valid),
        .cfg_err    (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
        m_err   = 1'b0;
        m_cfgd  = 1'b0;
        m_busy  = 1'b0;
        m_valid = 1'b0;
    endfunction

    // One keypress on the model, decided from pre-step positions.
    function automatic void model_step();
        bit r, m, a1, a2;
        r = (m_pos[0] == N0);
        m = (m_pos[1] == N1);
`ifdef DOUBLE_STEP_EN
        a1 = r || m;
        a2 = m;
`else
        a1 = r;
        a2 = r && m;
`endif
        m_pos[0] = (m_pos[0] + 1) % 26;
        if (a1) m_pos[1] = (m_pos[1] + 1) % 26;
        if (a2) m_pos[2] = (m_pos[2] + 1) % 26;
    endfunction

    function automatic void model_edge(input bit ld, input int i0, input int i1, input int i2, input bit sv);
        int iv [3];
        iv[0] = i0; iv[1] = i1; iv[2] = i2;
        if (ld) begin
            for (int i = 0; i < 3; i++) begin
                if (iv[i] >= 26) begin
                    m_pos[i] = 0;
                    m_err    = 1'b1;
                end else begin
                    m_pos[i] = iv[i];
                end
            end
            m_cfgd  = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end else if (m_cfgd && !m_busy && sv) begin
            model_step();
            m_busy  = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".pos_0"},      32'(pos_0),      32'(m_pos[0]));
        check({tag, ".pos_1"},      32'(pos_1),      32'(m_pos[1]));
        check({tag, ".pos_2"},      32'(pos_2),      32'(m_pos[2]));
        check({tag, ".pos_valid"},  32'(pos_valid),  32'(m_valid));
        check({tag, ".step_ready"}, 32'(step_ready), 32'(m_cfgd && !m_busy));
        check({tag, ".cfg_err"},    32'(cfg_err),    32'(m_err));
    endtask

    // Drive one clock of stimulus, update the model at the edge, check 1ns later.
    task automatic cycle(input string tag, input bit ld, input int i0, input int i1, input int i2, input bit sv);
        load_en    = ld;
        init_0     = 5'(i0);
        init_1     = 5'(i1);
        init_2     = 5'(i2);
        step_valid = sv;
        @(posedge clk);
        model_edge(ld, i0, i1, i2, sv);
        #1;
        load_en    = 1'b0;
        step_valid = 1'b0;
        check_model(tag);
    endtask

    task automatic check_pos(input string tag, input int e0, input int e1, input int e2);
        check({tag, ".p0"}, 32'(pos_0), 32'(e0));
        check({tag, ".p1"}, 32'(pos_1), 32'(e1));
        check({tag, ".p2"}, 32'(pos_2), 32'(e2));
    endtask

    initial begin
        int steps;
        int sel;
        int iv [3];
        rst_n      = 1'b0;
        load_en    = 1'b0;
        step_valid = 1'b0;
        init_0     = '0;
        init_1     = '0;
        init_2     = '0;
        model_reset();

        // Reset state and unconfigured block ignoring step requests
        #23;
        check_model("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("uncfg", 1'b0, 0, 0, 0, 1'b1);
        check_pos("uncfg_const", 0, 0, 0);
        check("uncfg_ready", 32'(step_ready), 32'd0);

        // Wrap of rotor 0 from 25 with no notch hit
        cycle("load25", 1'b1, 25, 25, 25, 1'b0);
        cycle("step25", 1'b0, 0, 0, 0, 1'b1);
        check_pos("wrap_const", 0, 25, 25);
        check("wrap_valid", 32'(pos_valid), 32'd1);
        check("wrap_ready", 32'(step_ready), 32'd0);
        cycle("after25", 1'b0, 0, 0, 0, 1'b0);
        check("wrap_valid_drop", 32'(pos_valid), 32'd0);

        // Notch sequence that distinguishes double-step from odometer
        cycle("load_ds", 1'b1, 16, 3, 0, 1'b0);
        cycle("ds1", 1'b0, 0, 0, 0, 1'b1);
        check_pos("ds1_const", 17, 4, 0);
        cycle("ds_gap", 1'b0, 0, 0, 0, 1'b0);
        cycle("ds2", 1'b0, 0, 0, 0, 1'b1);
`ifdef DOUBLE_STEP_EN
        check_pos("ds2_const", 18, 5, 1);
`else
        check_pos("ds2_const", 18, 4, 0);
`endif

        // Held step_valid: one step per two cycles
        cycle("load0", 1'b1, 0, 0, 0, 1'b0);
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            cycle("hold", 1'b0, 0, 0, 0, 1'b1);
            if (pos_valid === 1'b1) steps++;
        end
        check("hold_steps", 32'(steps), 32'd5);
        check_pos("hold_const", 5, 0, 0);

        // Load with a simultaneous step: step dropped
        cycle("load_sv", 1'b1, 7, 8, 9, 1'b1);
        check_pos("load_sv_const", 7, 8, 9);
        check("load_sv_valid", 32'(pos_valid), 32'd0);

        // Out-of-range init, sticky error flag
        cycle("load_bad", 1'b1, 1, 30, 2, 1'b0);
        check("bad_p1", 32'(pos_1), 32'd0);
        check("bad_err", 32'(cfg_err), 32'd1);
        cycle("load_good", 1'b1, 3, 4, 5, 1'b0);
        check("sticky_err", 32'(cfg_err), 32'd1);

        // Asynchronous reset while BUSY
        cycle("to_busy", 1'b0, 0, 0, 0, 1'b1);
        check("to_busy_valid", 32'(pos_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cycle("post_rst", 1'b0, 0, 0, 0, 1'b1);
        check("post_rst_ready", 32'(step_ready), 32'd0);

        // Randomized traffic with notch-biased load values
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 2)      iv[i] = (i == 0) ? N0 : N1;
                else if (sel < 4) iv[i] = (i == 0) ? N0 - 1 : N1 - 1;
                else if (sel < 5) iv[i] = 25;
                else if (sel < 6) iv[i] = int'($urandom_range(26, 31));
                else              iv[i] = int'($urandom_range(0, 25));
            end
            cycle($sformatf("rnd%0d", n), ($urandom_range(0, 19) == 0), iv[0], iv[1], iv[2],
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
